// File: rtl/reset_sequencer.sv
// Per-channel reset generator: asynchronous assertion from the global reset
// or the channel select, synchronised release, a programmable hold time, and
// software-requested timed reset pulses.
module reset_sequencer #(
    parameter int unsigned N_CH        = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [N_CH:1]   designs_cs,
    input  logic [N_CH:1]   sw_rst_req,
    output logic [N_CH:1]   designs_n_rst,
    output logic            all_run
);

    // Counter only needs to reach HOLD_CYCLES-1; keep at least one bit so
    // the HOLD_CYCLES == 0 configuration still elaborates cleanly.
    localparam int unsigned CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Per-channel asynchronous reset: global reset or channel select.
    logic [N_CH:1] async_n;

    // Merge the global reset with each channel select.
    always_comb begin
        async_n = {N_CH{n_rst}} & ~designs_cs;
    end

    for (genvar i = 1; i <= int'(N_CH); i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt;
        state_t                 state;
        logic                   run_q;
        logic                   synced;

        assign synced = sync_q[SYNC_STAGES-1];

        // Release synchroniser, hold counter and channel FSM; the output flop
        // mirrors state == RUN so the design reset is always flop-driven.
        always_ff @(posedge clk or negedge async_n[i]) begin
            if (!async_n[i]) begin
                sync_q <= '0;
                cnt    <= '0;
                state  <= ST_ASSERT;
                run_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
                case (state)
                    ST_ASSERT: begin
                        // Software requests are ignored until the hold phase.
                        if (synced) begin
                            cnt <= '0;
                            if (HOLD_CYCLES == 0) begin
                                state <= ST_RUN;
                                run_q <= 1'b1;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // A request restarts the hold time; cnt never wraps.
                        if (sw_rst_req[i]) begin
                            cnt <= '0;
                        end else if (cnt == CNT_W'(HOLD_LAST)) begin
                            cnt   <= '0;
                            state <= ST_RUN;
                            run_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (sw_rst_req[i]) begin
                            state <= ST_ASSERT;
                            run_q <= 1'b0;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_ASSERT;
                        run_q <= 1'b0;
                    end
                endcase
            end
        end

        assign designs_n_rst[i] = run_q;
    end

    // Every channel running; built from the per-channel RUN flops.
    always_comb begin
        all_run = &designs_n_rst;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default configuration (12 ch, 2 sync, hold 16)
// side by side with a 4 ch / 3 sync / hold 0 instance, both compared each
// cycle against a release-time model.
module tb_reset_sequencer;

    localparam int BIG = 1 << 30;

    logic        clk;
    logic        n_rst;
    logic [12:1] cs_a, sw_a, rst_a;
    logic        all_run_a;
    logic [4:1]  cs_b, sw_b, rst_b;
    logic        all_run_b;

    int vectors;
    int miscompares;
    int e;
    int k   [2][13];
    int rel [2][13];
    int ign [2][13];

    reset_sequencer #(.N_CH(12), .SYNC_STAGES(2), .HOLD_CYCLES(16)) dut_a (
        .clk(clk), .n_rst(n_rst), .designs_cs(cs_a), .sw_rst_req(sw_a),
        .designs_n_rst(rst_a), .all_run(all_run_a)
    );

    reset_sequencer #(.N_CH(4), .SYNC_STAGES(3), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .designs_cs(cs_b), .sw_rst_req(sw_b),
        .designs_n_rst(rst_b), .all_run(all_run_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int d);
        return (d == 0) ? 12 : 4;
    endfunction
    function automatic int s_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction
    function automatic int h_of(input int d);
        return (d == 0) ? 16 : 0;
    endfunction
    function automatic logic async_hi(input int d, input int i);
        if (d == 0) return n_rst & ~cs_a[i];
        return n_rst & ~cs_b[i];
    endfunction
    function automatic logic sw_bit(input int d, input int i);
        if (d == 0) return sw_a[i];
        return sw_b[i];
    endfunction

    // Model: each channel has an edge number at which its reset releases.
    // Async-high edge k=1 schedules release S+H edges later; requests are
    // ignored while the channel is still asserting (up to edge ign).
    task automatic model_edge();
        e++;
        for (int d = 0; d < 2; d++) begin
            for (int i = 1; i <= n_of(d); i++) begin
                if (!async_hi(d, i)) begin
                    k[d][i] = 0; rel[d][i] = BIG; ign[d][i] = BIG;
                end else begin
                    if (k[d][i] < 1000) k[d][i]++;
                    if (k[d][i] == 1) begin
                        rel[d][i] = e + s_of(d) + h_of(d);
                        ign[d][i] = e + s_of(d);
                    end else if (sw_bit(d, i) && e > ign[d][i]) begin
                        if (e > rel[d][i]) begin
                            rel[d][i] = e + 1 + h_of(d);
                            ign[d][i] = e + 1;
                        end else begin
                            rel[d][i] = e + h_of(d);
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic exp_bit(input int d, input int i);
        return async_hi(d, i) && (e >= rel[d][i]);
    endfunction

    task automatic check(input string tag);
        logic [12:1] ea;
        logic [4:1]  eb;
        for (int i = 1; i <= 12; i++) ea[i] = exp_bit(0, i);
        for (int i = 1; i <= 4; i++)  eb[i] = exp_bit(1, i);
        vectors++;
        assert (rst_a === ea) else begin
            miscompares++;
            $error("FAIL %s rst_a: observed %h expected %h (edge %0d)", tag, rst_a, ea, e);
        end
        vectors++;
        assert (all_run_a === (&ea)) else begin
            miscompares++;
            $error("FAIL %s all_run_a: observed %b expected %b (edge %0d)", tag, all_run_a, &ea, e);
        end
        vectors++;
        assert (rst_b === eb) else begin
            miscompares++;
            $error("FAIL %s rst_b: observed %h expected %h (edge %0d)", tag, rst_b, eb, e);
        end
        vectors++;
        assert (all_run_b === (&eb)) else begin
            miscompares++;
            $error("FAIL %s all_run_b: observed %b expected %b (edge %0d)", tag, all_run_b, &eb, e);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag);
    endtask

    // Edges from now until channel ch of instance d reads 1; -1 on timeout.
    task automatic wait_rise(input string tag, input int d, input int ch, output int edges);
        int start;
        logic v;
        start = e;
        edges = -1;
        for (int n = 0; n < 60; n++) begin
            v = (d == 0) ? rst_a[ch] : rst_b[ch];
            if (v === 1'b1) begin
                edges = e - start;
                break;
            end
            tick(tag);
        end
    endtask

    initial begin
        int ra, rb, t0, lows, r;
        vectors = 0; miscompares = 0; e = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 13; i++) begin
                k[d][i] = 0; rel[d][i] = BIG; ign[d][i] = BIG;
            end
        n_rst = 1'b0; cs_a = '0; sw_a = '0; cs_b = '0; sw_b = '0;

        // T1: power-on, release mid-cycle
        repeat (3) tick("reset");
        expect_int("reset_all_run_a", int'(all_run_a), 0);
        n_rst = 1'b1;
        ra = -1; rb = -1; t0 = e;
        for (int n = 0; n < 40; n++) begin
            tick("t1_release");
            if (ra < 0 && all_run_a === 1'b1) ra = e - t0;
            if (rb < 0 && all_run_b === 1'b1) rb = e - t0;
        end
        expect_int("t1_latency_a", ra, 19);
        expect_int("t1_latency_b", rb, 4);

        // T2: cs[3] asserted asynchronously during RUN
        cs_a[3] = 1'b1;
        #1;
        check("t2_cs_async");
        expect_int("t2_ch3_low", int'(rst_a[3]), 0);
        repeat (3) tick("t2_cs_held");
        cs_a[3] = 1'b0;
        wait_rise("t2_release", 0, 3, r);
        expect_int("t2_latency", r, 19);
        repeat (2) tick("t2_settle");

        // T3: single software pulse on ch5
        sw_a[5] = 1'b1;
        tick("t3_pulse");
        sw_a[5] = 1'b0;
        lows = 0;
        for (int n = 0; n < 40; n++) begin
            if (rst_a[5] !== 1'b0) break;
            lows++;
            tick("t3_low");
        end
        expect_int("t3_low_cycles", lows, 17);
        repeat (2) tick("t3_settle");

        // T4: retrigger at edge t+12 moves release to t+28
        sw_a[5] = 1'b1;
        tick("t4_pulse1");
        sw_a[5] = 1'b0;
        t0 = e;
        repeat (11) tick("t4_hold");
        sw_a[5] = 1'b1;
        tick("t4_pulse2");
        sw_a[5] = 1'b0;
        wait_rise("t4_release", 0, 5, r);
        expect_int("t4_release_edge", e - t0, 28);
        repeat (2) tick("t4_settle");

        // T5: global reset while channels are in HOLD
        n_rst = 1'b0;
        repeat (2) tick("t5_pre");
        n_rst = 1'b1;
        repeat (6) tick("t5_hold");
        n_rst = 1'b0;
        #1;
        check("t5_async");
        expect_int("t5_all_low", int'(rst_a), 0);
        tick("t5_in_reset");
        n_rst = 1'b1;
        wait_rise("t5_release", 0, 1, r);
        expect_int("t5_latency", r, 19);
        repeat (2) tick("t5_settle");

        // T6: hold-0 instance, sw pulse and cs+sw together
        sw_b[1] = 1'b1;
        tick("t6_sw");
        sw_b[1] = 1'b0;
        expect_int("t6_sw_low", int'(rst_b[1]), 0);
        tick("t6_sw_back");
        expect_int("t6_sw_one_cycle", int'(rst_b[1]), 1);
        cs_b[2] = 1'b1; sw_b[2] = 1'b1;
        repeat (3) tick("t6_cs_sw");
        sw_b[2] = 1'b0;
        repeat (3) tick("t6_cs_only");
        expect_int("t6_cs_hold", int'(rst_b[2]), 0);
        cs_b[2] = 1'b0;
        wait_rise("t6_release", 1, 2, r);
        expect_int("t6_latency", r, 4);

        // Random phase: sparse sw requests (sometimes multi-cycle), cs toggles, global reset pulses
        for (int n = 0; n < 800; n++) begin
            for (int i = 1; i <= 12; i++) begin
                sw_a[i] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 59) == 0) cs_a[i] = ~cs_a[i];
            end
            for (int i = 1; i <= 4; i++) begin
                sw_b[i] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 29) == 0) cs_b[i] = ~cs_b[i];
            end
            if (n_rst == 1'b0) n_rst = 1'b1;
            else if ($urandom_range(0, 249) == 0) n_rst = 1'b0;
            tick("random");
        end

        // Drain: everything released, expect all running
        sw_a = '0; sw_b = '0; cs_a = '0; cs_b = '0; n_rst = 1'b1;
        repeat (25) tick("drain");
        expect_int("drain_all_run_a", int'(all_run_a), 1);
        expect_int("drain_all_run_b", int'(all_run_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
